// File: rtl/coreabc_init_loader_if.sv
// Boot byte stream and CoreABC instruction-RAM init port, bundled for the loader.
// The slave side is the loader; the master side is the boot source and RAM observer.
interface coreabc_init_loader_if #(
  parameter int INITWIDTH = 7
);
  logic [7:0]           SRC_DATA;
  logic                 SRC_VALID;
  logic                 SRC_READY;
  logic [INITWIDTH-1:0] INITADDR;
  logic [8:0]           INITDATA;
  logic                 INITDATVAL;
  logic                 INITDONE;
  logic                 INITERR;

  modport master (
    output SRC_DATA, SRC_VALID,
    input  SRC_READY, INITADDR, INITDATA, INITDATVAL, INITDONE, INITERR
  );

  modport slave (
    input  SRC_DATA, SRC_VALID,
    output SRC_READY, INITADDR, INITDATA, INITDATVAL, INITDONE, INITERR
  );
endinterface

// File: rtl/coreabc_init_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte image and writes the
// 9-bit words to consecutive CoreABC instruction-RAM addresses via the init port.
module coreabc_init_loader #(
  parameter int          INITWIDTH = 7,
  parameter int unsigned TIMEOUT   = 32'd65535
) (
  input  logic                 CLK,
  input  logic                 RESET,
  coreabc_init_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_CNTL = 3'd1,
    S_CNTH = 3'd2,
    S_DLO  = 3'd3,
    S_DHI  = 3'd4,
    S_CHK  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  localparam logic [16:0] MAX_WORDS  = 17'd1 << INITWIDTH;
  localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT - 32'd1);
  localparam bit          TIMEOUT_EN = (TIMEOUT != 32'd0);

  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

  state_t               state_r;
  logic [7:0]           sum_r;
  logic [7:0]           lo_r;
  logic [15:0]          num_r;
  logic [15:0]          word_cnt_r;
  logic [15:0]          idle_cnt_r;
  logic                 src_ready_r;
  logic [INITWIDTH-1:0] initaddr_r;
  logic [8:0]           initdata_r;
  logic                 initdatval_r;
  logic                 initdone_r;
  logic                 initerr_r;

  logic                 rx_s;
  logic                 accept_s;
  logic                 timeout_s;
  logic [15:0]          num_s;
  logic [15:0]          word_next_s;

  assign rx_s        = (state_r inside {S_CNTL, S_CNTH, S_DLO, S_DHI, S_CHK});
  assign accept_s    = bus.SRC_VALID & src_ready_r;
  assign timeout_s   = TIMEOUT_EN && rx_s && !bus.SRC_VALID && (idle_cnt_r == IDLE_LAST);
  assign num_s       = {bus.SRC_DATA, num_r[7:0]};
  assign word_next_s = word_cnt_r + 16'd1;

  // Image parser FSM together with its counters and every registered output
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= IDLE;
      sum_r        <= 8'd0;
      lo_r         <= 8'd0;
      num_r        <= 16'd0;
      word_cnt_r   <= 16'd0;
      idle_cnt_r   <= 16'd0;
      src_ready_r  <= 1'b0;
      initaddr_r   <= '0;
      initdata_r   <= 9'd0;
      initdatval_r <= 1'b0;
      initdone_r   <= 1'b0;
      initerr_r    <= 1'b0;
    end else begin
      initdatval_r <= 1'b0;
      // Address moves on only after the write it belongs to has been presented
      if (initdatval_r) begin
        initaddr_r <= initaddr_r + INITWIDTH'(1'b1);
      end
      if (!rx_s || accept_s) begin
        idle_cnt_r <= 16'd0;
      end else begin
        idle_cnt_r <= idle_cnt_r + 16'd1;
      end
      if (accept_s) begin
        sum_r <= chk_add(sum_r, bus.SRC_DATA);
      end

      if (timeout_s) begin
        state_r     <= S_ERR;
        src_ready_r <= 1'b0;
        initdone_r  <= 1'b1;
        initerr_r   <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            sum_r       <= 8'd0;
            word_cnt_r  <= 16'd0;
            src_ready_r <= 1'b1;
            state_r     <= S_CNTL;
          end
          S_CNTL: begin
            if (accept_s) begin
              num_r[7:0] <= bus.SRC_DATA;
              state_r    <= S_CNTH;
            end
          end
          S_CNTH: begin
            if (accept_s) begin
              num_r[15:8] <= bus.SRC_DATA;
              if (num_s == 16'd0) begin
                state_r <= S_CHK;
              end else if ({1'b0, num_s} > MAX_WORDS) begin
                state_r     <= S_ERR;
                src_ready_r <= 1'b0;
                initdone_r  <= 1'b1;
                initerr_r   <= 1'b1;
              end else begin
                state_r <= S_DLO;
              end
            end
          end
          S_DLO: begin
            if (accept_s) begin
              lo_r    <= bus.SRC_DATA;
              state_r <= S_DHI;
            end
          end
          S_DHI: begin
            if (accept_s) begin
              if (bus.SRC_DATA[7:1] != 7'd0) begin
                state_r     <= S_ERR;
                src_ready_r <= 1'b0;
                initdone_r  <= 1'b1;
                initerr_r   <= 1'b1;
              end else begin
                initdata_r   <= {bus.SRC_DATA[0], lo_r};
                initdatval_r <= 1'b1;
                word_cnt_r   <= word_next_s;
                state_r      <= (word_next_s == num_r) ? S_CHK : S_DLO;
              end
            end
          end
          S_CHK: begin
            if (accept_s) begin
              src_ready_r <= 1'b0;
              initdone_r  <= 1'b1;
              if (chk_add(sum_r, bus.SRC_DATA) == 8'd0) begin
                state_r <= S_DONE;
              end else begin
                state_r   <= S_ERR;
                initerr_r <= 1'b1;
              end
            end
          end
          default: begin
            state_r <= state_r;
          end
        endcase
      end
    end
  end

  assign bus.SRC_READY  = src_ready_r;
  assign bus.INITADDR   = initaddr_r;
  assign bus.INITDATA   = initdata_r;
  assign bus.INITDATVAL = initdatval_r;
  assign bus.INITDONE   = initdone_r;
  assign bus.INITERR    = initerr_r;

endmodule

// File: tb/tb_coreabc_init_loader.sv
// Directed bench for coreabc_init_loader: a table of whole images plus
// hand-written timeout, reset-mid-load and full-size sequences.
module tb_coreabc_init_loader;

  localparam int INITWIDTH = 7;

  typedef struct packed {
    logic [8:0][7:0]  img;
    logic [3:0]       len;
    logic             toggle;
    logic [1:0]       nwr;
    logic [2:0][15:0] wr;
    logic             done;
    logic             err;
  } vec_t;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b1;
  int          checks = 0;
  int          errors = 0;
  bit          overlap = 1'b0;
  logic [15:0] wr_q[$];

  coreabc_init_loader_if #(.INITWIDTH(INITWIDTH)) bus ();

  coreabc_init_loader #(
    .INITWIDTH(INITWIDTH),
    .TIMEOUT  (32'd16)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Record each write as {addr, data}; flag any strobe while done is up
  always @(negedge CLK) begin
    if (bus.INITDATVAL === 1'b1) begin
      wr_q.push_back({bus.INITADDR, bus.INITDATA});
      if (bus.INITDONE === 1'b1) overlap = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one byte from a negedge and returns at the negedge after it is taken
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.SRC_DATA  = b;
    bus.SRC_VALID = 1'b1;
    while (bus.SRC_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("accept", 32'(bus.SRC_READY === 1'b1), 32'd1);
    if (bus.SRC_READY === 1'b1) @(negedge CLK);
    bus.SRC_VALID = 1'b0;
  endtask

  task automatic do_reset();
    bus.SRC_VALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    wr_q.delete();
  endtask

  function automatic vec_t mk(input logic [71:0] img, input logic [3:0] len, input logic toggle,
                              input logic [1:0] nwr, input logic [47:0] wr,
                              input logic done, input logic err);
    vec_t v;
    v.img = img; v.len = len; v.toggle = toggle; v.nwr = nwr;
    v.wr = wr; v.done = done; v.err = err;
    return v;
  endfunction

  initial begin
    vec_t       tbl[8];
    logic [7:0] norm[9];
    logic [7:0] s;
    int         idx;

    // 0x96 makes the byte sum of this image wrap to zero
    norm = '{8'h03, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01, 8'h33, 8'h00, 8'h96};

    tbl[0] = mk(72'({8'h03,8'h00,8'h11,8'h00,8'h22,8'h01,8'h33,8'h00,8'h96}), 4'd9, 1'b0, 2'd3,
                48'({16'h0011,16'h0322,16'h0433}), 1'b1, 1'b0);
    tbl[1] = mk(72'({8'h00,8'h00,8'h00}), 4'd3, 1'b1, 2'd0, 48'd0, 1'b1, 1'b0);
    tbl[2] = mk(72'({8'h03,8'h00,8'h11,8'h00,8'h22,8'h01,8'h33,8'h00,8'h97}), 4'd9, 1'b0, 2'd3,
                48'({16'h0011,16'h0322,16'h0433}), 1'b1, 1'b1);
    tbl[3] = mk(72'({8'h03,8'h00,8'h11,8'h00,8'h22,8'h01,8'h33,8'h00,8'h7B}), 4'd9, 1'b0, 2'd3,
                48'({16'h0011,16'h0322,16'h0433}), 1'b1, 1'b1);
    tbl[4] = mk(72'({8'h01,8'h00,8'h55,8'h02}), 4'd4, 1'b0, 2'd0, 48'd0, 1'b1, 1'b1);
    tbl[5] = mk(72'({8'h81,8'h00}), 4'd2, 1'b0, 2'd0, 48'd0, 1'b1, 1'b1);
    tbl[6] = mk(72'({8'h01,8'h00,8'hFF,8'h01,8'hFF}), 4'd5, 1'b0, 2'd1, 48'(16'h01FF), 1'b1, 1'b0);
    tbl[7] = mk(72'({8'h03,8'h00,8'h11,8'h00,8'h22,8'h01,8'h33,8'h00,8'h96}), 4'd9, 1'b1, 2'd3,
                48'({16'h0011,16'h0322,16'h0433}), 1'b1, 1'b0);

    // Reset values, then one IDLE cycle before the loader becomes ready
    bus.SRC_DATA  = 8'd0;
    bus.SRC_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(bus.SRC_READY), 32'd0);
    check("rst_addr", 32'(bus.INITADDR), 32'd0);
    check("rst_data", 32'(bus.INITDATA), 32'd0);
    check("rst_val", 32'(bus.INITDATVAL), 32'd0);
    check("rst_done", 32'(bus.INITDONE), 32'd0);
    check("rst_err", 32'(bus.INITERR), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    check("ready_after_idle", 32'(bus.SRC_READY), 32'd1);

    for (int t = 0; t < 8; t++) begin
      do_reset();
      for (int i = 0; i < int'(tbl[t].len); i++) begin
        if (tbl[t].toggle) begin
          bus.SRC_VALID = 1'b0;
          @(negedge CLK);
        end
        idx = int'(tbl[t].len) - 1 - i;
        send(tbl[t].img[idx]);
      end
      check($sformatf("v%0d_done", t), 32'(bus.INITDONE), 32'(tbl[t].done));
      check($sformatf("v%0d_err", t), 32'(bus.INITERR), 32'(tbl[t].err));
      check($sformatf("v%0d_ready", t), 32'(bus.SRC_READY), 32'd0);
      @(negedge CLK);
      check($sformatf("v%0d_nwr", t), 32'(wr_q.size()), 32'(tbl[t].nwr));
      for (int k = 0; k < int'(tbl[t].nwr) && k < wr_q.size(); k++) begin
        idx = int'(tbl[t].nwr) - 1 - k;
        check($sformatf("v%0d_wr%0d", t, k), 32'(wr_q[k]), 32'(tbl[t].wr[idx]));
      end
    end

    // Timeout: 16 idle cycles inside a word
    do_reset();
    send(8'h02); send(8'h00); send(8'h11);
    repeat (15) @(negedge CLK);
    check("to_err_early", 32'(bus.INITERR), 32'd0);
    check("to_done_early", 32'(bus.INITDONE), 32'd0);
    @(negedge CLK);
    check("to_err", 32'(bus.INITERR), 32'd1);
    check("to_done", 32'(bus.INITDONE), 32'd1);
    check("to_ready", 32'(bus.SRC_READY), 32'd0);
    check("to_nwr", 32'(wr_q.size()), 32'd0);

    // Reset after the second word of a 4-word image, then a clean reload
    do_reset();
    send(8'h04); send(8'h00); send(8'h11); send(8'h00); send(8'h22); send(8'h01);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_addr", 32'(bus.INITADDR), 32'd0);
    check("mid_data", 32'(bus.INITDATA), 32'd0);
    check("mid_val", 32'(bus.INITDATVAL), 32'd0);
    check("mid_ready", 32'(bus.SRC_READY), 32'd0);
    check("mid_done", 32'(bus.INITDONE), 32'd0);
    check("mid_err", 32'(bus.INITERR), 32'd0);
    RESET = 1'b0;
    wr_q.delete();
    for (int i = 0; i < 9; i++) send(norm[i]);
    check("reload_done", 32'(bus.INITDONE), 32'd1);
    check("reload_err", 32'(bus.INITERR), 32'd0);
    @(negedge CLK);
    check("reload_nwr", 32'(wr_q.size()), 32'd3);
    if (wr_q.size() == 3) begin
      check("reload_wr0", 32'(wr_q[0]), 32'h0011);
      check("reload_wr1", 32'(wr_q[1]), 32'h0322);
      check("reload_wr2", 32'(wr_q[2]), 32'h0433);
    end

    // Full-size image: 128 words, address wraps back to 0 afterwards
    do_reset();
    s = 8'h80;
    send(8'h80); send(8'h00);
    for (int i = 0; i < 128; i++) begin
      send(8'(i));
      send({7'd0, 1'(i)});
      s = s + 8'(i) + {7'd0, 1'(i)};
    end
    send(8'd0 - s);
    check("full_done", 32'(bus.INITDONE), 32'd1);
    check("full_err", 32'(bus.INITERR), 32'd0);
    @(negedge CLK);
    check("full_nwr", 32'(wr_q.size()), 32'd128);
    for (int i = 0; i < 128 && i < wr_q.size(); i++) begin
      check($sformatf("full_wr%0d", i), 32'(wr_q[i]), 32'({7'(i), 1'(i), 8'(i)}));
    end
    check("full_addr_wrap", 32'(bus.INITADDR), 32'd0);

    check("val_done_overlap", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
